// File: rtl/router_input_queue_pkg.sv
// Shared channel geometry, FSM state types and flit helpers for the router input queue.
// Channel width and the header-flag position are fixed here for the whole router slice.
package router_input_queue_pkg;

    localparam int CHANNEL_WIDTH          = 32;
    localparam int HEADER_BIT             = CHANNEL_WIDTH - 1;
    localparam int PACKET_FLITS_DEFAULT   = 5;
    localparam int BUFFER_PACKETS_DEFAULT = 2;

    typedef enum logic [0:0] {
        CAP_IDLE = 1'b0,
        CAP_BODY = 1'b1
    } cap_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE   = 2'd0,
        OUT_REQ    = 2'd1,
        OUT_STREAM = 2'd2
    } out_state_e;

    function automatic logic is_header(input logic [CHANNEL_WIDTH-1:0] flit);
        return flit[HEADER_BIT];
    endfunction

endpackage

// File: rtl/router_input_queue_flit_fifo.sv
// First-word fall-through flit FIFO with arbitrary (non power-of-two) depth.
// A write while full is accepted only when a read frees a slot in the same cycle.
module flit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? AW'(0) : ptr + AW'(1);
    endfunction

    assign rd_ok_s = rd_en && (count_r != CW'(0));
    assign wr_ok_s = wr_en && ((count_r != CW'(DEPTH)) || rd_ok_s);

    // Storage array; payload needs no reset
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));
    assign dout  = mem_r[rd_ptr_r];

endmodule

// File: rtl/router_input_queue.sv
// Store-and-forward router input port: captures whole packets, requests the arbiter, streams on grant.
// Optional status outputs (occupancy, sticky overflow) are built when ROUTER_INPUT_QUEUE_STATUS_EN is defined.
module router_input_queue
    import router_input_queue_pkg::*;
#(
    parameter int BUFFER_PACKETS = BUFFER_PACKETS_DEFAULT,
    parameter int PACKET_FLITS   = PACKET_FLITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNEL_WIDTH-1:0] input_channel_din,
    output logic                     credit_out_dout,
    output logic                     request_valid_dout,
    output logic [CHANNEL_WIDTH-1:0] header_flit_dout,
    input  logic                     grant_din,
    output logic                     flit_valid_dout,
    output logic [CHANNEL_WIDTH-1:0] flit_dout
`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
    ,
    output logic [$clog2(BUFFER_PACKETS+1)-1:0] occupancy_dout,
    output logic                                overflow_error_dout
`endif
);

    localparam int DEPTH = BUFFER_PACKETS * PACKET_FLITS;
    localparam int FW    = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
    localparam int CW    = $clog2(BUFFER_PACKETS + 1);
    localparam logic [FW-1:0] LAST_FLIT = FW'(PACKET_FLITS - 1);

    cap_state_e         cap_state_r, cap_next_s;
    out_state_e         out_state_r, out_next_s;
    logic [FW-1:0]      fcnt_r, fcnt_next_s;
    logic [FW-1:0]      scnt_r, scnt_next_s;
    logic [CW-1:0]      pkt_count_r;
    logic               cap_write_s, pkt_done_s, pkt_inc_s;
    logic               request_valid_s, flit_valid_s, credit_s;
    logic               fifo_wr_s, rd_en_s, fifo_full_s, fifo_empty_s;
    logic [CHANNEL_WIDTH-1:0] fifo_head_s;

    flit_fifo #(.WIDTH(CHANNEL_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (fifo_wr_s),
        .din   (input_channel_din),
        .rd_en (rd_en_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .dout  (fifo_head_s)
    );

    // Capture FSM and stream FSM state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_state_r <= CAP_IDLE;
            fcnt_r      <= FW'(0);
            out_state_r <= OUT_IDLE;
            scnt_r      <= FW'(0);
        end else begin
            cap_state_r <= cap_next_s;
            fcnt_r      <= fcnt_next_s;
            out_state_r <= out_next_s;
            scnt_r      <= scnt_next_s;
        end
    end

    // Capture next-state: header opens a packet, body flits are taken blindly
    always_comb begin
        cap_write_s = 1'b0;
        pkt_done_s  = 1'b0;
        cap_next_s  = cap_state_r;
        fcnt_next_s = fcnt_r;
        case (cap_state_r)
            CAP_IDLE: begin
                if (is_header(input_channel_din)) begin
                    cap_write_s = 1'b1;
                    fcnt_next_s = FW'(1);
                    cap_next_s  = CAP_BODY;
                end else begin
                    fcnt_next_s = FW'(0);
                end
            end
            CAP_BODY: begin
                cap_write_s = 1'b1;
                if (fcnt_r == LAST_FLIT) begin
                    pkt_done_s  = 1'b1;
                    fcnt_next_s = FW'(0);
                    cap_next_s  = CAP_IDLE;
                end else begin
                    fcnt_next_s = fcnt_r + FW'(1);
                end
            end
            default: begin
                fcnt_next_s = FW'(0);
                cap_next_s  = CAP_IDLE;
            end
        endcase
    end

    // Stream next-state; a packet completing this cycle already counts as waiting
    always_comb begin
        out_next_s  = out_state_r;
        scnt_next_s = scnt_r;
        case (out_state_r)
            OUT_IDLE: begin
                if ((pkt_count_r != CW'(0)) || pkt_done_s) begin
                    out_next_s = OUT_REQ;
                end else begin
                    out_next_s = OUT_IDLE;
                end
                scnt_next_s = FW'(0);
            end
            OUT_REQ: begin
                if (grant_din) begin
                    out_next_s = OUT_STREAM;
                end else begin
                    out_next_s = OUT_REQ;
                end
                scnt_next_s = FW'(0);
            end
            OUT_STREAM: begin
                if (scnt_r == LAST_FLIT) begin
                    scnt_next_s = FW'(0);
                    if ((pkt_count_r > CW'(1)) || pkt_done_s) begin
                        out_next_s = OUT_REQ;
                    end else begin
                        out_next_s = OUT_IDLE;
                    end
                end else begin
                    scnt_next_s = scnt_r + FW'(1);
                end
            end
            default: begin
                out_next_s  = OUT_IDLE;
                scnt_next_s = FW'(0);
            end
        endcase
    end

    // Stream outputs decoded from registered state only
    always_comb begin
        request_valid_s = 1'b0;
        flit_valid_s    = 1'b0;
        credit_s        = 1'b0;
        case (out_state_r)
            OUT_REQ:    request_valid_s = 1'b1;
            OUT_STREAM: begin
                flit_valid_s = 1'b1;
                credit_s     = (scnt_r == LAST_FLIT);
            end
            default: begin
                request_valid_s = 1'b0;
            end
        endcase
    end

    assign rd_en_s   = flit_valid_s && !fifo_empty_s;
    assign fifo_wr_s = cap_write_s && (!fifo_full_s || rd_en_s);
    // An overflowed packet never becomes a stored packet, so the count saturates
    assign pkt_inc_s = pkt_done_s && ((pkt_count_r != CW'(BUFFER_PACKETS)) || credit_s);

    // Complete-packet count: simultaneous complete and drain cancel out
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_count_r <= CW'(0);
        end else if (pkt_inc_s && !credit_s) begin
            pkt_count_r <= pkt_count_r + CW'(1);
        end else if (!pkt_inc_s && credit_s) begin
            pkt_count_r <= pkt_count_r - CW'(1);
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end

    assign credit_out_dout    = credit_s;
    assign request_valid_dout = request_valid_s;
    assign header_flit_dout   = request_valid_s ? fifo_head_s : '0;
    assign flit_valid_dout    = flit_valid_s;
    assign flit_dout          = flit_valid_s ? fifo_head_s : '0;

`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
    logic overflow_error_r;
    logic drop_s;

    assign drop_s = cap_write_s && fifo_full_s && !rd_en_s;

    // Sticky record of any flit lost to an upstream credit violation
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_error_r <= 1'b0;
        end else if (drop_s) begin
            overflow_error_r <= 1'b1;
        end else begin
            overflow_error_r <= overflow_error_r;
        end
    end

    assign occupancy_dout      = pkt_count_r;
    assign overflow_error_dout = overflow_error_r;
`endif

endmodule

// File: tb/tb_router_input_queue.sv
// Self-checking bench for router_input_queue: directed timing scenarios plus randomized traffic
// scored against a packet-level queue model of what the port must deliver.
module tb_router_input_queue;

    localparam int BP = 2;
    localparam int PF = 5;
    localparam int W  = 32;

    typedef logic [PF-1:0][W-1:0] pkt_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         grant;
    logic         credit_out_dout;
    logic         request_valid_dout;
    logic [W-1:0] header_flit_dout;
    logic         flit_valid_dout;
    logic [W-1:0] flit_dout;
`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
    logic [1:0]   occupancy_dout;
    logic         overflow_error_dout;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    pkt_t exp_q[$];
    int   rx_idx = 0;
    int   sent = 0;
    int   credits_rcvd = 0;
    int   grant_mode = 3;

    router_input_queue dut (
        .clk                (clk),
        .reset              (reset),
        .input_channel_din  (din),
        .credit_out_dout    (credit_out_dout),
        .request_valid_dout (request_valid_dout),
        .header_flit_dout   (header_flit_dout),
        .grant_din          (grant),
        .flit_valid_dout    (flit_valid_dout),
        .flit_dout          (flit_dout)
`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
        ,
        .occupancy_dout     (occupancy_dout),
        .overflow_error_dout(overflow_error_dout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] idle_word();
        return {1'b0, 31'($urandom)};
    endfunction

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p[0] = {1'b1, 31'($urandom)};
        for (int i = 1; i < PF; i++) p[i] = $urandom;
        return p;
    endfunction

    // Packet-level scoreboard: streamed flits must match accepted packets in arrival order
    task automatic monitor();
        if (flit_valid_dout) begin
            chk_eq("req_during_stream", 32'(request_valid_dout), 32'd0);
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_flit", flit_dout, 32'hFFFF_FFFF);
            end else begin
                chk_eq("flit", flit_dout, exp_q[0][rx_idx]);
                chk_eq("credit_on_last", 32'(credit_out_dout), 32'(rx_idx == PF - 1));
                rx_idx++;
                if (rx_idx == PF) begin
                    void'(exp_q.pop_front());
                    rx_idx = 0;
                end
            end
        end else if (credit_out_dout) begin
            chk_eq("credit_idle", 32'd1, 32'd0);
        end
        if (credit_out_dout) credits_rcvd++;
        if (request_valid_dout) begin
            if (exp_q.size() > 0) chk_eq("req_header", header_flit_dout, exp_q[0][0]);
            else                  chk_eq("req_unexpected", 32'd1, 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
        case (grant_mode)
            0:       grant = 1'b0;
            1:       grant = ($urandom_range(0, 2) == 0);
            2:       grant = 1'b1;
            default: grant = grant;
        endcase
    endtask

    task automatic send_pkt(input pkt_t p, input bit accept);
        if (accept) exp_q.push_back(p);
        sent++;
        for (int i = 0; i < PF; i++) begin
            din = p[i];
            tick();
        end
        din = idle_word();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din = idle_word();
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        grant_mode = 3;
        grant = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            din = {1'b1, 31'($urandom)};
            tick();
            chk_eq("rst_req", 32'(request_valid_dout), 32'd0);
            chk_eq("rst_fv", 32'(flit_valid_dout), 32'd0);
            chk_eq("rst_credit", 32'(credit_out_dout), 32'd0);
            chk_eq("rst_hdr", header_flit_dout, 32'd0);
            chk_eq("rst_flit", flit_dout, 32'd0);
`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
            chk_eq("rst_occ", 32'(occupancy_dout), 32'd0);
            chk_eq("rst_ovf", 32'(overflow_error_dout), 32'd0);
`endif
        end
        reset = 1'b1;
        grant = 1'b0;
        din = idle_word();
        exp_q.delete();
        rx_idx = 0;
        sent = 0;
        credits_rcvd = 0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!request_valid_dout && k < 60) begin
            din = idle_word();
            tick();
            k++;
        end
        chk_eq("req_wait", 32'(request_valid_dout), 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        grant_mode = 2;
        while ((exp_q.size() != 0 || flit_valid_dout) && k < 300) begin
            din = idle_word();
            tick();
            k++;
        end
        chk_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        pkt_t p;
        int k;
        reset = 1'b0;
        grant = 1'b0;
        din = '0;

        // 1: reset with junk on the channel
        do_reset(3);

        // 2: single packet, exact latency
        do_reset(1);
        p = rand_pkt();
        p[0] = 32'hC000_1234;
        exp_q.push_back(p);
        sent++;
        for (int i = 0; i < PF; i++) begin
            din = p[i];
            tick();
            if (i == 3) chk_eq("t4_req", 32'(request_valid_dout), 32'd0);
        end
        din = idle_word();
        chk_eq("t5_req", 32'(request_valid_dout), 32'd1);
        chk_eq("t5_hdr", header_flit_dout, 32'hC000_1234);
        tick();
        chk_eq("t6_req", 32'(request_valid_dout), 32'd1);
        chk_eq("t6_fv", 32'(flit_valid_dout), 32'd0);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk_eq("t7_fv", 32'(flit_valid_dout), 32'd1);
        chk_eq("t7_req", 32'(request_valid_dout), 32'd0);
        chk_eq("t7_flit", flit_dout, 32'hC000_1234);
        for (int t = 8; t <= 11; t++) begin
            tick();
            chk_eq("stream_fv", 32'(flit_valid_dout), 32'd1);
            chk_eq("stream_credit", 32'(credit_out_dout), 32'(t == 11));
        end
        tick();
        chk_eq("t12_fv", 32'(flit_valid_dout), 32'd0);
        chk_eq("t12_credit", 32'(credit_out_dout), 32'd0);
        chk_eq("t2_credits", 32'(credits_rcvd), 32'd1);

        // 3: back-to-back packets held until both stored
        do_reset(1);
        grant_mode = 0;
        send_pkt(rand_pkt(), 1'b1);
        send_pkt(rand_pkt(), 1'b1);
        idle(3);
        chk_eq("b2b_req", 32'(request_valid_dout), 32'd1);
`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
        chk_eq("b2b_occ", 32'(occupancy_dout), 32'd2);
`endif
        drain();
        chk_eq("b2b_credits", 32'(credits_rcvd), 32'd2);

        // 4: third packet written while the first drains from a full FIFO
        do_reset(1);
        grant_mode = 0;
        send_pkt(rand_pkt(), 1'b1);
        send_pkt(rand_pkt(), 1'b1);
        wait_req();
        grant_mode = 3;
        grant = 1'b1;
        din = idle_word();
        tick();
        chk_eq("sim_stream_start", 32'(flit_valid_dout), 32'd1);
        grant_mode = 2;
        send_pkt(rand_pkt(), 1'b1);
        drain();
        chk_eq("sim_credits", 32'(credits_rcvd), 32'd3);
`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
        chk_eq("sim_no_ovf", 32'(overflow_error_dout), 32'd0);
`endif

        // 5: credit violation, third packet is dropped
        do_reset(1);
        grant_mode = 0;
        send_pkt(rand_pkt(), 1'b1);
        send_pkt(rand_pkt(), 1'b1);
        send_pkt(rand_pkt(), 1'b0);
        idle(2);
`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
        chk_eq("ovf_set", 32'(overflow_error_dout), 32'd1);
        chk_eq("ovf_occ", 32'(occupancy_dout), 32'd2);
`endif
        drain();
        idle(3);
        chk_eq("ovf_credits", 32'(credits_rcvd), 32'd2);
        chk_eq("ovf_no_req", 32'(request_valid_dout), 32'd0);
`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
        chk_eq("ovf_sticky", 32'(overflow_error_dout), 32'd1);
`endif

        // 6: reset in the middle of a stream
        do_reset(1);
        grant_mode = 0;
        send_pkt(rand_pkt(), 1'b1);
        wait_req();
        grant_mode = 2;
        k = 0;
        while (rx_idx < 2 && k < 20) begin
            din = idle_word();
            tick();
            k++;
        end
        chk_eq("mid_reached", 32'(rx_idx), 32'd2);
        grant_mode = 3;
        reset = 1'b0;
        tick();
        chk_eq("mid_fv", 32'(flit_valid_dout), 32'd0);
        chk_eq("mid_credit", 32'(credit_out_dout), 32'd0);
        chk_eq("mid_cred_count", 32'(credits_rcvd), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        rx_idx = 0;
        sent = 0;
        credits_rcvd = 0;
        send_pkt(rand_pkt(), 1'b1);
        drain();
        chk_eq("mid_after_credits", 32'(credits_rcvd), 32'd1);

        // Randomized traffic honouring upstream credits
        do_reset(1);
        grant_mode = 1;
        for (int n = 0; n < 30; n++) begin
            idle($urandom_range(0, 3));
            k = 0;
            while ((BP - sent + credits_rcvd) <= 0 && k < 100) begin
                din = idle_word();
                tick();
                k++;
            end
            chk_eq("rand_credit_avail", 32'((BP - sent + credits_rcvd) > 0), 32'd1);
            send_pkt(rand_pkt(), 1'b1);
        end
        drain();
        chk_eq("rand_credits", 32'(credits_rcvd), 32'(sent));
`ifdef ROUTER_INPUT_QUEUE_STATUS_EN
        chk_eq("rand_no_ovf", 32'(overflow_error_dout), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
